// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module : mult_div_unit
// Desc   : Multicycle MIPS-style HI/LO multiply/divide unit with MTHI/MTLO.
// Rev    : 1.0  initial release
// ============================================================================
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int C_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int C_CNT_W      = ($clog2(C_MAX_CYCLES + 1) > 4) ? $clog2(C_MAX_CYCLES + 1) : 4;

    localparam logic [C_CNT_W-1:0] C_MULT_LOAD = C_CNT_W'(MULT_CYCLES);
    localparam logic [C_CNT_W-1:0] C_DIV_LOAD  = C_CNT_W'(DIV_CYCLES);

    localparam logic [2:0] C_OP_MULT  = 3'd0;
    localparam logic [2:0] C_OP_MULTU = 3'd1;
    localparam logic [2:0] C_OP_DIV   = 3'd2;
    localparam logic [2:0] C_OP_DIVU  = 3'd3;
    localparam logic [2:0] C_OP_MTHI  = 3'd4;
    localparam logic [2:0] C_OP_MTLO  = 3'd5;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t               r_state, w_state_next;
    logic [C_CNT_W-1:0]   r_count, w_count_next;
    logic [31:0]          r_a, w_a_next;
    logic [31:0]          r_b, w_b_next;
    logic [2:0]           r_op, w_op_next;
    logic [31:0]          r_hi, w_hi_next;
    logic [31:0]          r_lo, w_lo_next;
    logic                 r_busy;

    // Arithmetic on the latched operands
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_a_neg;
    logic        w_b_neg;
    logic        w_div_zero;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [31:0] w_mag_q;
    logic [31:0] w_mag_r;
    logic [31:0] w_sq;
    logic [31:0] w_sr;
    logic [31:0] w_uq;
    logic [31:0] w_ur;

    assign w_prod_s = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
    assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};

    // Signed divide via magnitudes; -2^31 / -1 naturally yields 0x80000000 rem 0.
    assign w_a_neg    = r_a[31];
    assign w_b_neg    = r_b[31];
    assign w_div_zero = (r_b == 32'd0);
    assign w_abs_a    = w_a_neg ? (~r_a + 32'd1) : r_a;
    assign w_abs_b    = w_b_neg ? (~r_b + 32'd1) : r_b;
    assign w_mag_q    = w_div_zero ? 32'd0 : (w_abs_a / w_abs_b);
    assign w_mag_r    = w_div_zero ? 32'd0 : (w_abs_a % w_abs_b);
    assign w_sq       = (w_a_neg ^ w_b_neg) ? (~w_mag_q + 32'd1) : w_mag_q;
    assign w_sr       = w_a_neg ? (~w_mag_r + 32'd1) : w_mag_r;
    assign w_uq       = w_div_zero ? 32'd0 : (r_a / r_b);
    assign w_ur       = w_div_zero ? 32'd0 : (r_a % r_b);

    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_a_next     = r_a;
        w_b_next     = r_b;
        w_op_next    = r_op;
        w_hi_next    = r_hi;
        w_lo_next    = r_lo;

        if (r_state == ST_IDLE) begin
            if (start) begin
                case (op)
                    C_OP_MULT, C_OP_MULTU: begin
                        w_a_next     = a;
                        w_b_next     = b;
                        w_op_next    = op;
                        w_count_next = C_MULT_LOAD;
                        w_state_next = ST_RUN;
                    end
                    C_OP_DIV, C_OP_DIVU: begin
                        w_a_next     = a;
                        w_b_next     = b;
                        w_op_next    = op;
                        w_count_next = C_DIV_LOAD;
                        w_state_next = ST_RUN;
                    end
                    C_OP_MTHI: w_hi_next = a;
                    C_OP_MTLO: w_lo_next = a;
                    default: ;
                endcase
            end
        end else begin
            if (r_count <= C_CNT_W'(1)) begin
                w_state_next = ST_IDLE;
                w_count_next = '0;
                case (r_op)
                    C_OP_MULT: begin
                        w_hi_next = w_prod_s[63:32];
                        w_lo_next = w_prod_s[31:0];
                    end
                    C_OP_MULTU: begin
                        w_hi_next = w_prod_u[63:32];
                        w_lo_next = w_prod_u[31:0];
                    end
                    C_OP_DIV: begin
                        if (!w_div_zero) begin
                            w_hi_next = w_sr;
                            w_lo_next = w_sq;
                        end
                    end
                    C_OP_DIVU: begin
                        if (!w_div_zero) begin
                            w_hi_next = w_ur;
                            w_lo_next = w_uq;
                        end
                    end
                    default: ;
                endcase
            end else begin
                w_count_next = r_count - C_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            r_a     <= w_a_next;
            r_b     <= w_b_next;
            r_op    <= w_op_next;
            r_hi    <= w_hi_next;
            r_lo    <= w_lo_next;
            r_busy  <= (w_state_next == ST_RUN);
        end
    end

    assign busy      = r_busy;
    assign stall_req = r_busy | (start & ~op[2]);
    assign hi        = r_hi;
    assign lo        = r_lo;

endmodule
`default_nettype wire
